txn_relation_tracker: RTL and testbench

Synthesizable transaction-stream tracker: the hardware successor of the simulation-side stream/relation bookkeeping. It keeps one open transaction per stream for `NUM_STREAMS` streams and allocates non-zero transaction IDs. It auto-closes a stream's previous transaction when a new one begins and records parent ("source") relations. Every begin/end/relation event goes out as an ordered record through a buffered valid/ready port to the trace logger.

---
 rtl/txn_rel_pkg.sv | 49 ++++
 rtl/txn_rel_fifo.sv | 53 +++++
 rtl/txn_relation_tracker.sv | 190 +++++++++++++++++++
 tb/tb_txn_relation_tracker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/txn_rel_pkg.sv
// Shared types for the transaction relation tracker: command/event/error
// encodings, FSM states and the event record carried to the trace logger.
package txn_rel_pkg;

    // Upper bounds for the record fields; the tracker stores only the
    // configured SW / ID_W slices in its FIFO.
    localparam int SW_MAX = 8;
    localparam int ID_MAX = 32;

    localparam logic [ID_MAX-1:0] NULL_ID = '0;

    typedef enum logic [1:0] {
        OP_ILL   = 2'b00,
        OP_BEGIN = 2'b01,
        OP_END   = 2'b10,
        OP_FLUSH = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        EV_NONE  = 2'b00,
        EV_BEGIN = 2'b01,
        EV_END   = 2'b10,
        EV_REL   = 2'b11
    } ev_kind_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_END_CLOSED = 2'd1,
        ERR_BAD_PARENT = 2'd2,
        ERR_BAD_OP     = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLOSE_PREV,
        ST_OPEN,
        ST_RELATE,
        ST_CLOSE,
        ST_FLUSH
    } state_e;

    typedef struct packed {
        ev_kind_e            kind;
        logic [SW_MAX-1:0]   stream;
        logic [ID_MAX-1:0]   id;
        logic [ID_MAX-1:0]   aux;
    } ev_rec_t;

endpackage

// File: rtl/txn_rel_fifo.sv
// Synchronous FIFO with a registered head: dout always shows the oldest
// entry (or zero when empty) and only changes on a clock edge.
module txn_rel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr, rd_ptr_n;
    logic [AW:0]                 count, count_pop;
    logic                        do_push, do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    // A full FIFO refuses a push even if the head is popped this cycle.
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_ptr_n  = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    assign count_pop = count - (AW+1)'(do_pop);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count_pop + (AW+1)'(do_push);
            if (count_pop == '0) dout <= do_push ? din : '0;
            else                 dout <= mem[rd_ptr_n];
        end
    end

endmodule

// File: rtl/txn_relation_tracker.sv
// Per-stream open-transaction tracker. Allocates non-zero IDs, auto-closes
// a stream's previous transaction on BEGIN, records parent relations and
// emits ordered BEGIN/END/REL records through a FIFO to the trace logger.
module txn_relation_tracker
    import txn_rel_pkg::*;
#(
    parameter int NUM_STREAMS = 5,
    parameter int ID_W        = 16,
    parameter int FIFO_DEPTH  = 8,
    localparam int SW = $clog2((NUM_STREAMS > 1) ? NUM_STREAMS : 2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [SW-1:0]          cmd_stream,
    input  logic                   cmd_rel_en,
    input  logic [SW-1:0]          cmd_parent,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [1:0]             ev_kind,
    output logic [SW-1:0]          ev_stream,
    output logic [ID_W-1:0]        ev_id,
    output logic [ID_W-1:0]        ev_aux,
    output logic [NUM_STREAMS-1:0] open_mask,
    output logic                   err_valid,
    output logic [1:0]             err_code
);

    localparam int EW = 2 + SW + 2*ID_W;

    state_e                             state;
    logic [NUM_STREAMS-1:0]             open_q;
    logic [NUM_STREAMS-1:0][ID_W-1:0]   cur_id;
    logic [ID_W-1:0]                    id_ctr;
    logic [SW-1:0]                      lat_stream, lat_parent;
    logic                               lat_rel, lat_bad;
    logic                               err_q;
    logic [1:0]                         err_code_q;

    logic                               push, full, empty, pop;
    ev_rec_t                            rec;
    logic [EW-1:0]                      push_data, pop_data;
    logic                               stream_ok, rel_ok, bad_rel_now;
    logic                               flush_any;
    logic [SW-1:0]                      flush_idx;
    logic [NUM_STREAMS-1:0]             flush_rest;

    assign stream_ok = ({1'b0, cmd_stream} < (SW+1)'(NUM_STREAMS));
    // Relation is judged against the open set as seen at acceptance.
    assign rel_ok    = ({1'b0, cmd_parent} < (SW+1)'(NUM_STREAMS)) &&
                       open_q[cmd_parent] && (cmd_parent != cmd_stream);

    // Lowest-index open stream: the next one a FLUSH closes.
    always_comb begin
        flush_any = 1'b0;
        flush_idx = '0;
        for (int i = NUM_STREAMS-1; i >= 0; i--) begin
            if (open_q[i]) begin
                flush_any = 1'b1;
                flush_idx = SW'(i);
            end
        end
    end
    assign flush_rest = open_q & ~(NUM_STREAMS'(1) << flush_idx);

    // Event record for the current emitting state; pushes wait while full.
    always_comb begin
        push = 1'b0;
        rec  = '0;
        case (state)
            ST_CLOSE_PREV, ST_CLOSE: begin
                push       = !full;
                rec.kind   = EV_END;
                rec.stream = SW_MAX'(lat_stream);
                rec.id     = ID_MAX'(cur_id[lat_stream]);
            end
            ST_OPEN: begin
                push       = !full;
                rec.kind   = EV_BEGIN;
                rec.stream = SW_MAX'(lat_stream);
                rec.id     = ID_MAX'(id_ctr);
            end
            ST_RELATE: begin
                push       = !full;
                rec.kind   = EV_REL;
                rec.stream = SW_MAX'(lat_stream);
                rec.id     = ID_MAX'(cur_id[lat_stream]);
                rec.aux    = ID_MAX'(cur_id[lat_parent]);
            end
            ST_FLUSH: begin
                push       = flush_any && !full;
                rec.kind   = EV_END;
                rec.stream = SW_MAX'(flush_idx);
                rec.id     = ID_MAX'(cur_id[flush_idx]);
            end
            default: ;
        endcase
    end

    assign push_data = {rec.kind, rec.stream[SW-1:0], rec.id[ID_W-1:0], rec.aux[ID_W-1:0]};

    txn_rel_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .dout  (pop_data)
    );

    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;
    assign {ev_kind, ev_stream, ev_id, ev_aux} = pop_data;

    assign cmd_ready   = (state == ST_IDLE);
    assign open_mask   = open_q;
    // Bad-parent error is tied to the cycle the BEGIN record actually goes out.
    assign bad_rel_now = (state == ST_OPEN) && push && lat_bad;
    assign err_valid   = err_q | bad_rel_now;
    assign err_code    = err_q ? err_code_q : (bad_rel_now ? ERR_BAD_PARENT : ERR_NONE);

    // Command FSM plus per-stream open/ID bookkeeping and the ID allocator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            open_q     <= '0;
            cur_id     <= '0;
            id_ctr     <= ID_W'(1);
            lat_stream <= '0;
            lat_parent <= '0;
            lat_rel    <= 1'b0;
            lat_bad    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    lat_stream <= cmd_stream;
                    lat_parent <= cmd_parent;
                    lat_rel    <= cmd_rel_en && rel_ok;
                    lat_bad    <= cmd_rel_en && !rel_ok;
                    if (cmd_op == OP_FLUSH) begin
                        state <= ST_FLUSH;
                    end else if (cmd_op == OP_ILL || !stream_ok) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BAD_OP;
                    end else if (cmd_op == OP_BEGIN) begin
                        state <= open_q[cmd_stream] ? ST_CLOSE_PREV : ST_OPEN;
                    end else if (open_q[cmd_stream]) begin
                        state <= ST_CLOSE;
                    end else begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_END_CLOSED;
                    end
                end
                ST_CLOSE_PREV: if (!full) begin
                    open_q[lat_stream] <= 1'b0;
                    state              <= ST_OPEN;
                end
                ST_OPEN: if (!full) begin
                    open_q[lat_stream] <= 1'b1;
                    cur_id[lat_stream] <= id_ctr;
                    id_ctr             <= (id_ctr == '1) ? ID_W'(1) : id_ctr + ID_W'(1);
                    state              <= lat_rel ? ST_RELATE : ST_IDLE;
                end
                ST_RELATE: if (!full) state <= ST_IDLE;
                ST_CLOSE: if (!full) begin
                    open_q[lat_stream] <= 1'b0;
                    state              <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (!flush_any) begin
                        state <= ST_IDLE;
                    end else if (!full) begin
                        open_q[flush_idx] <= 1'b0;
                        if (flush_rest == '0) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_txn_relation_tracker.sv
// Directed bench for txn_relation_tracker (5 streams, 3-bit IDs, 4-deep FIFO).
module tb_txn_relation_tracker;

    localparam logic [1:0] OP_B = 2'b01, OP_E = 2'b10, OP_F = 2'b11, OP_X = 2'b00;
    localparam logic [1:0] K_B = 2'd1, K_E = 2'd2, K_R = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] stream;
        logic [2:0] id;
        logic [2:0] aux;
    } ev_t;

    typedef struct packed {
        logic [1:0]      op;
        logic [2:0]      stream;
        logic            rel;
        logic [2:0]      parent;
        logic [2:0]      n;
        ev_t [3:0]       ev;
        logic [1:0]      err;
        logic [4:0]      mask;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_rel_en = 1'b0, ev_ready = 1'b1;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_stream = '0, cmd_parent = '0;
    logic       cmd_ready, ev_valid, err_valid;
    logic [1:0] ev_kind, err_code;
    logic [2:0] ev_stream, ev_id, ev_aux;
    logic [4:0] open_mask;

    int n_chk = 0, n_fail = 0, cyc = 0, err_cnt = 0;
    logic [1:0] err_last = '0;
    ev_t obs_q[$];
    int  obs_cyc[$];
    vec_t vt[14];
    ev_t  exp_q[$];

    txn_relation_tracker #(.NUM_STREAMS(5), .ID_W(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_stream(cmd_stream), .cmd_rel_en(cmd_rel_en), .cmd_parent(cmd_parent),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind),
        .ev_stream(ev_stream), .ev_id(ev_id), .ev_aux(ev_aux),
        .open_mask(open_mask), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic ev_t mk_ev(input logic [1:0] k, input logic [2:0] s, input logic [2:0] id, input logic [2:0] aux);
        ev_t e;
        e.kind = k; e.stream = s; e.id = id; e.aux = aux;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [1:0] op, input logic [2:0] s, input logic rel,
                                    input logic [2:0] p, input logic [2:0] n, input ev_t e0, input ev_t e1,
                                    input ev_t e2, input ev_t e3, input logic [1:0] err, input logic [4:0] mask);
        vec_t v;
        v.op = op; v.stream = s; v.rel = rel; v.parent = p; v.n = n;
        v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2; v.ev[3] = e3;
        v.err = err; v.mask = mask;
        return v;
    endfunction

    // Event and error monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ev_valid && ev_ready) begin
                obs_q.push_back(mk_ev(ev_kind, ev_stream, ev_id, ev_aux));
                obs_cyc.push_back(cyc);
            end
            if (err_valid) begin
                err_cnt++;
                err_last = err_code;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        err_cnt  = 0;
        err_last = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [2:0] s, input logic rel, input logic [2:0] p);
        int t;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cmd_ready) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_ready_timeout: got 0, want 1");
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_stream = s; cmd_rel_en = rel; cmd_parent = p;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = OP_X; cmd_rel_en = 1'b0;
    endtask

    task automatic chk_events(input string tag);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size())
                chk($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t z;
        z = '0;
        vt[0]  = mk_vec(OP_B, 0, 0, 0, 1, mk_ev(K_B,0,1,0), z, z, z, 0, 5'b00001);
        vt[1]  = mk_vec(OP_B, 1, 1, 0, 2, mk_ev(K_B,1,2,0), mk_ev(K_R,1,2,1), z, z, 0, 5'b00011);
        vt[2]  = mk_vec(OP_B, 1, 1, 0, 3, mk_ev(K_E,1,2,0), mk_ev(K_B,1,3,0), mk_ev(K_R,1,3,1), z, 0, 5'b00011);
        vt[3]  = mk_vec(OP_E, 3, 0, 0, 0, z, z, z, z, 1, 5'b00011);
        vt[4]  = mk_vec(OP_B, 2, 1, 4, 1, mk_ev(K_B,2,4,0), z, z, z, 2, 5'b00111);
        vt[5]  = mk_vec(OP_B, 3, 1, 3, 1, mk_ev(K_B,3,5,0), z, z, z, 2, 5'b01111);
        vt[6]  = mk_vec(OP_E, 2, 0, 0, 1, mk_ev(K_E,2,4,0), z, z, z, 0, 5'b01011);
        vt[7]  = mk_vec(OP_X, 0, 0, 0, 0, z, z, z, z, 3, 5'b01011);
        vt[8]  = mk_vec(OP_B, 5, 0, 0, 0, z, z, z, z, 3, 5'b01011);
        vt[9]  = mk_vec(OP_B, 4, 1, 7, 1, mk_ev(K_B,4,6,0), z, z, z, 2, 5'b11011);
        vt[10] = mk_vec(OP_F, 0, 0, 0, 4, mk_ev(K_E,0,1,0), mk_ev(K_E,1,3,0), mk_ev(K_E,3,5,0), mk_ev(K_E,4,6,0), 0, 5'b00000);
        vt[11] = mk_vec(OP_F, 0, 0, 0, 0, z, z, z, z, 0, 5'b00000);
        vt[12] = mk_vec(OP_B, 0, 0, 0, 1, mk_ev(K_B,0,7,0), z, z, z, 0, 5'b00001);
        vt[13] = mk_vec(OP_B, 0, 1, 2, 2, mk_ev(K_E,0,7,0), mk_ev(K_B,0,1,0), z, z, 2, 5'b00001);

        // Reset state, sampled while reset is held.
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_ev_valid", 32'(ev_valid), 0);
        chk("rst_ev_fields", 32'({ev_kind, ev_stream, ev_id, ev_aux}), 0);
        chk("rst_open_mask", 32'(open_mask), 0);
        chk("rst_err", 32'({err_valid, err_code}), 0);
        do_reset();

        // First-event latency and error pulse timing.
        do_cmd(OP_B, 0, 0, 0);
        @(negedge clk);
        chk("lat_c1_ev_valid", 32'(ev_valid), 0);
        chk("lat_c1_open_mask", 32'(open_mask), 0);
        @(negedge clk);
        chk("lat_c2_ev_valid", 32'(ev_valid), 1);
        chk("lat_c2_event", 32'(mk_ev(ev_kind, ev_stream, ev_id, ev_aux)), 32'(mk_ev(K_B,0,1,0)));
        chk("lat_c2_open_mask", 32'(open_mask), 1);
        @(posedge clk); #1;
        do_cmd(OP_E, 3, 0, 0);
        @(negedge clk);
        chk("err1_c1", 32'({err_valid, err_code}), 32'({1'b1, 2'd1}));
        @(negedge clk);
        chk("err1_c2", 32'(err_valid), 0);

        // Table of single commands from a fresh reset.
        do_reset();
        for (int v = 0; v < 14; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            clear_obs();
            exp_q.delete();
            for (int i = 0; i < 32'(vt[v].n); i++) exp_q.push_back(vt[v].ev[i]);
            do_cmd(vt[v].op, vt[v].stream, vt[v].rel, vt[v].parent);
            repeat (10) @(posedge clk);
            #1;
            chk_events(tag);
            chk({tag, "_err_pulses"}, 32'(err_cnt), (vt[v].err != 0) ? 1 : 0);
            chk({tag, "_err_code"}, 32'(err_last), 32'(vt[v].err));
            chk({tag, "_open_mask"}, 32'(open_mask), 32'(vt[v].mask));
        end

        // Back-pressure: 4-deep FIFO fills and stalls the third BEGIN.
        do_reset();
        ev_ready = 1'b0;
        do_cmd(OP_B, 0, 0, 0);
        do_cmd(OP_B, 0, 0, 0);
        do_cmd(OP_B, 0, 0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 0);
        chk("full_head", 32'(mk_ev(ev_kind, ev_stream, ev_id, ev_aux)), 32'(mk_ev(K_B,0,1,0)));
        chk("full_open_mask", 32'(open_mask), 0);
        @(posedge clk); #1;
        ev_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        exp_q.delete();
        exp_q.push_back(mk_ev(K_B,0,1,0)); exp_q.push_back(mk_ev(K_E,0,1,0));
        exp_q.push_back(mk_ev(K_B,0,2,0)); exp_q.push_back(mk_ev(K_E,0,2,0));
        exp_q.push_back(mk_ev(K_B,0,3,0));
        chk_events("drain");
        chk("drain_open_mask", 32'(open_mask), 1);

        // ID wrap with 3-bit IDs: 1..7 then 1.
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            do_cmd(OP_B, 0, 0, 0);
            if (k > 0) exp_q.push_back(mk_ev(K_E, 0, 3'((k-1) % 7 + 1), 0));
            exp_q.push_back(mk_ev(K_B, 0, 3'(k % 7 + 1), 0));
        end
        repeat (10) @(posedge clk);
        #1;
        chk_events("wrap");

        // FLUSH of s0/s2/s4 on consecutive cycles, then reset mid-flush.
        do_reset();
        do_cmd(OP_B, 0, 0, 0);
        do_cmd(OP_B, 2, 0, 0);
        do_cmd(OP_B, 4, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        clear_obs();
        do_cmd(OP_F, 0, 0, 0);
        repeat (8) @(posedge clk);
        #1;
        exp_q.delete();
        exp_q.push_back(mk_ev(K_E,0,1,0)); exp_q.push_back(mk_ev(K_E,2,2,0));
        exp_q.push_back(mk_ev(K_E,4,3,0));
        chk_events("flush");
        if (obs_cyc.size() == 3) begin
            chk("flush_gap01", 32'(obs_cyc[1] - obs_cyc[0]), 1);
            chk("flush_gap12", 32'(obs_cyc[2] - obs_cyc[1]), 1);
        end
        chk("flush_open_mask", 32'(open_mask), 0);
        do_cmd(OP_B, 0, 0, 0);
        do_cmd(OP_B, 2, 0, 0);
        do_cmd(OP_B, 4, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        clear_obs();
        do_cmd(OP_F, 0, 0, 0);
        @(posedge clk); #1;
        chk("midflush_pre_ev_valid", 32'(ev_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midflush_ev_valid", 32'(ev_valid), 0);
        chk("midflush_open_mask", 32'(open_mask), 0);
        chk("midflush_cmd_ready", 32'(cmd_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midflush_no_events", 32'(obs_q.size()), 0);
        chk("midflush_post_mask", 32'(open_mask), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
